gpio_mmio_port: RTL and testbench

//  Memory-mapped GPIO peripheral: the core-side end of the gpio_port_out / gpio_port_in pins
//  of the riscv_factorial system. The core reads and writes registers over a simple

---
 rtl/gpio_mmio_port_if.sv | 23 ++
 rtl/gpio_mmio_port.sv | 130 +++++++++++++
 tb/tb_gpio_mmio_port.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_mmio_port_if.sv
// Single-beat register bus between the core and the GPIO peripheral.
// An access is bus_sel & (bus_we | bus_re); bus_ready pulses exactly one cycle later with bus_rdata.
interface gpio_mmio_port_if #(
    parameter int ADDR_W = 5
) ();
    logic              bus_sel;
    logic              bus_we;
    logic              bus_re;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_sel, bus_we, bus_re, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_sel, bus_we, bus_re, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/gpio_mmio_port.sv
// Memory-mapped GPIO: registered outputs, synchronized inputs with sticky rising-edge
// flags, a saturating edge counter on pin 0 and a maskable level interrupt.
module gpio_mmio_port #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    gpio_mmio_port_if.slave    bus,
    input  logic [WIDTH-1:0]   gpio_port_in,
    output logic [WIDTH-1:0]   gpio_port_out,
    output logic               irq
);
    localparam logic [2:0]       REG_OUT  = 3'd0;
    localparam logic [2:0]       REG_IN   = 3'd1;
    localparam logic [2:0]       REG_STAT = 3'd2;
    localparam logic [2:0]       REG_MASK = 3'd3;
    localparam logic [2:0]       REG_CNT  = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_arm;
    logic [31:0]      r_rdata;
    logic             r_ready;
    logic             r_irq;

    logic             w_access;
    logic             w_wr;
    logic             w_rd;
    logic             w_both;
    logic [2:0]       w_idx;
    logic [WIDTH-1:0] w_wdata;
    logic             w_armed;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_status_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      w_rdata_mux;
    logic             w_unused;

    assign w_access = bus.bus_sel & (bus.bus_we | bus.bus_re);
    assign w_wr     = bus.bus_sel & bus.bus_we;
    assign w_rd     = bus.bus_sel & bus.bus_re & ~bus.bus_we;
    assign w_both   = bus.bus_sel & bus.bus_re & bus.bus_we;
    assign w_idx    = bus.bus_addr[4:2];
    assign w_wdata  = bus.bus_wdata[WIDTH-1:0];
    assign w_unused = &{1'b0, bus.bus_addr[1:0], bus.bus_wdata};

    // Edges are ignored until the synchronizer has flushed its post-reset contents.
    assign w_armed = (r_arm == 2'd3);
    assign w_rise  = r_s2 & ~r_prev & {WIDTH{w_armed}};
    assign w_clr   = (w_wr && w_idx == REG_STAT) ? w_wdata : '0;

    always_comb begin
        w_status_next = (r_status & ~w_clr) | w_rise;
    end

    always_comb begin
        w_cnt_next = r_count;
        if (w_wr && w_idx == REG_CNT) begin
            w_cnt_next    = '0;
            w_cnt_next[0] = w_rise[0];
        end else if (w_rise[0] && r_count != CNT_MAX) begin
            w_cnt_next = r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_rdata_mux = '0;
        case (w_idx)
            REG_OUT:  w_rdata_mux[WIDTH-1:0] = r_out;
            REG_IN:   w_rdata_mux[WIDTH-1:0] = r_s2;
            REG_STAT: w_rdata_mux[WIDTH-1:0] = r_status;
            REG_MASK: w_rdata_mux[WIDTH-1:0] = r_mask;
            REG_CNT:  w_rdata_mux[CNT_W-1:0] = r_count;
            default:  w_rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_prev   <= '0;
            r_status <= '0;
            r_mask   <= '0;
            r_count  <= '0;
            r_arm    <= '0;
            r_rdata  <= '0;
            r_ready  <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_s1     <= gpio_port_in;
            r_s2     <= r_s1;
            r_prev   <= r_s2;
            if (!w_armed) begin
                r_arm <= r_arm + 2'd1;
            end
            r_status <= w_status_next;
            r_count  <= w_cnt_next;
            r_ready  <= w_access;
            r_irq    <= |(r_status & r_mask);
            if (w_wr && w_idx == REG_OUT) begin
                r_out <= w_wdata;
            end
            if (w_wr && w_idx == REG_MASK) begin
                r_mask <= w_wdata;
            end
            // A combined read+write is a write; its read data is defined as zero.
            if (w_both) begin
                r_rdata <= '0;
            end else if (w_rd) begin
                r_rdata <= w_rdata_mux;
            end
        end
    end

    assign gpio_port_out = r_out;
    assign irq           = r_irq;
    assign bus.bus_rdata = r_rdata;
    assign bus.bus_ready = r_ready;
endmodule

// File: tb/tb_gpio_mmio_port.sv
// Bench for gpio_mmio_port: vector table, directed corner sequences, and a random
// phase checked against a settled-pin register model.
module tb_gpio_mmio_port;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pins = 8'h00;
    logic [7:0] pins2 = 8'h00;
    logic [7:0] gout;
    logic [7:0] gout2;
    logic       irq;
    logic       irq2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    gpio_mmio_port_if #(.ADDR_W(5)) bif ();
    gpio_mmio_port_if #(.ADDR_W(5)) bif2 ();

    gpio_mmio_port #(.WIDTH(8), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bif.slave),
        .gpio_port_in(pins), .gpio_port_out(gout), .irq(irq)
    );

    gpio_mmio_port #(.WIDTH(8), .ADDR_W(5), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bif2.slave),
        .gpio_port_in(pins2), .gpio_port_out(gout2), .irq(irq2)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    // Reference model state (settled-pin view of the peripheral).
    logic [7:0] m_out, m_mask, m_status, m_pins;
    int         m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bif.bus_sel = 1'b0; bif.bus_we = 1'b0; bif.bus_re = 1'b0;
        bif.bus_addr = '0; bif.bus_wdata = '0;
    endtask

    // All bus tasks are entered at a negedge and return at a negedge.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bif.bus_sel = 1'b1; bif.bus_we = 1'b1; bif.bus_re = 1'b0;
        bif.bus_addr = a; bif.bus_wdata = d;
        @(negedge clk);
        chk("wr_ready", {31'b0, bif.bus_ready}, 32'd1);
        bus_idle();
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        bif.bus_sel = 1'b1; bif.bus_we = 1'b0; bif.bus_re = 1'b1;
        bif.bus_addr = a; bif.bus_wdata = '0;
        @(negedge clk);
        chk("rd_ready", {31'b0, bif.bus_ready}, 32'd1);
        d = bif.bus_rdata;
        bus_idle();
    endtask

    task automatic bus2_read(input logic [4:0] a, output logic [31:0] d);
        bif2.bus_sel = 1'b1; bif2.bus_re = 1'b1; bif2.bus_addr = a;
        @(negedge clk);
        chk("rd2_ready", {31'b0, bif2.bus_ready}, 32'd1);
        d = bif2.bus_rdata;
        bif2.bus_sel = 1'b0; bif2.bus_re = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse0();
        pins[0] = 1'b1;
        repeat (3) @(negedge clk);
        pins[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse0_b();
        pins2[0] = 1'b1;
        repeat (3) @(negedge clk);
        pins2[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return {24'b0, m_out};
            3'd1:    return {24'b0, m_pins};
            3'd2:    return {24'b0, m_status};
            3'd3:    return {24'b0, m_mask};
            3'd4:    return 32'(m_count);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  np;
        logic [4:0]  ra;
        logic [31:0] rw;

        vecs[0] = '{5'h00, 32'hFFFF_FFA5, 32'h0000_00A5};
        vecs[1] = '{5'h03, 32'h0000_005A, 32'h0000_005A};
        vecs[2] = '{5'h0C, 32'h0000_1234, 32'h0000_0034};
        vecs[3] = '{5'h0E, 32'h0000_00C3, 32'h0000_00C3};
        vecs[4] = '{5'h04, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{5'h08, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6] = '{5'h10, 32'h1234_5678, 32'h0000_0000};
        vecs[7] = '{5'h14, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8] = '{5'h18, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9] = '{5'h1C, 32'hFFFF_FFFF, 32'h0000_0000};

        bus_idle();
        bif2.bus_sel = 1'b0; bif2.bus_we = 1'b0; bif2.bus_re = 1'b0;
        bif2.bus_addr = '0; bif2.bus_wdata = '0;
        @(negedge clk);
        do_reset();
        @(negedge clk);

        chk("rst_out",   {24'b0, gout}, 32'h0);
        chk("rst_irq",   {31'b0, irq}, 32'h0);
        chk("rst_ready", {31'b0, bif.bus_ready}, 32'h0);
        chk("rst_rdata", bif.bus_rdata, 32'h0);

        for (int i = 0; i < 10; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            chk($sformatf("vec%0d", i), rd, vecs[i].exp);
        end
        bus_write(5'h0C, 32'h0);

        // Output write visible the cycle after the strobe, ready exactly one cycle.
        bif.bus_sel = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = 5'h00; bif.bus_wdata = 32'h2A;
        chk("out_before", {24'b0, gout}, 32'h5A);
        @(negedge clk);
        chk("out_after", {24'b0, gout}, 32'h2A);
        chk("wr_ready_pulse", {31'b0, bif.bus_ready}, 32'h1);
        bus_idle();
        @(negedge clk);
        chk("ready_drop", {31'b0, bif.bus_ready}, 32'h0);
        bus_read(5'h00, rd);
        chk("read_out", rd, 32'h2A);

        // Input synchronizer latency and edge flag.
        pins = 8'h08;
        @(negedge clk);
        bus_read(5'h04, rd);
        chk("in_early", rd, 32'h00);
        bus_read(5'h04, rd);
        chk("in_3rd", rd, 32'h08);
        bus_read(5'h08, rd);
        chk("status_pin3", rd, 32'h08);

        // Interrupt, same-cycle set/clear, and clear latency.
        bus_write(5'h0C, 32'h08);
        bus_write(5'h08, 32'h08);
        pins = 8'h00;
        repeat (4) @(negedge clk);
        chk("irq_clear0", {31'b0, irq}, 32'h0);
        pins = 8'h08;
        repeat (5) @(negedge clk);
        chk("irq_pulse", {31'b0, irq}, 32'h1);
        pins = 8'h00;
        repeat (4) @(negedge clk);
        pins = 8'h08;
        @(negedge clk);
        @(negedge clk);
        bus_write(5'h08, 32'h08);
        chk("irq_setwins", {31'b0, irq}, 32'h1);
        bus_read(5'h08, rd);
        chk("status_setwins", rd, 32'h08);
        chk("irq_hold", {31'b0, irq}, 32'h1);
        bus_write(5'h08, 32'h08);
        chk("irq_lag", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_drop", {31'b0, irq}, 32'h0);

        // Pins high through reset must not set flags or count.
        pins = 8'hFF;
        do_reset();
        repeat (10) @(negedge clk);
        bus_read(5'h08, rd);
        chk("arm_status", rd, 32'h0);
        bus_read(5'h10, rd);
        chk("arm_count", rd, 32'h0);
        bus_read(5'h04, rd);
        chk("arm_in", rd, 32'hFF);

        // Edge counter, clear, and clear racing a rise.
        pins = 8'h00;
        repeat (4) @(negedge clk);
        repeat (5) pulse0();
        bus_read(5'h10, rd);
        chk("count5", rd, 32'd5);
        bus_write(5'h10, 32'h0);
        bus_read(5'h10, rd);
        chk("count_clr", rd, 32'd0);
        repeat (2) pulse0();
        pins[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_write(5'h10, 32'h0);
        bus_read(5'h10, rd);
        chk("count_race", rd, 32'd1);
        pins[0] = 1'b0;
        repeat (3) @(negedge clk);
        repeat (20) pulse0_b();
        bus2_read(5'h10, rd);
        chk("count_sat", rd, 32'd15);

        // Combined read+write, unmapped read, reset during a read.
        bus_write(5'h00, 32'h2A);
        bus_read(5'h00, rd);
        chk("rd_pre", rd, 32'h2A);
        bif.bus_sel = 1'b1; bif.bus_we = 1'b1; bif.bus_re = 1'b1;
        bif.bus_addr = 5'h00; bif.bus_wdata = 32'h55;
        @(negedge clk);
        chk("both_ready", {31'b0, bif.bus_ready}, 32'h1);
        chk("both_rdata", bif.bus_rdata, 32'h0);
        chk("both_out", {24'b0, gout}, 32'h55);
        bus_idle();
        bus_read(5'h00, rd);
        chk("rd_55", rd, 32'h55);
        bus_read(5'h1C, rd);
        chk("unmapped", rd, 32'h0);
        bif.bus_sel = 1'b1; bif.bus_re = 1'b1; bif.bus_addr = 5'h00;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, bif.bus_ready}, 32'h0);
        chk("rst_mid_out", {24'b0, gout}, 32'h0);
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Random phase: pins change only while the bus is idle, then settle.
        m_out = '0; m_mask = '0; m_status = '0; m_pins = '0; m_count = 0;
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    np = 8'($urandom);
                    m_status = m_status | (np & ~m_pins);
                    if (np[0] && !m_pins[0] && m_count < 65535) m_count++;
                    m_pins = np;
                    pins = np;
                    repeat (4) @(negedge clk);
                end
                1: begin
                    ra = 5'($urandom_range(0, 31));
                    rw = $urandom;
                    if (ra[4:2] == 3'd0 && $urandom_range(0, 1) == 1) rw[7:0] = 8'hFF;
                    bus_write(ra, rw);
                    case (ra[4:2])
                        3'd0: m_out = rw[7:0];
                        3'd2: m_status = m_status & ~rw[7:0];
                        3'd3: m_mask = rw[7:0];
                        3'd4: m_count = 0;
                        default: ;
                    endcase
                    chk("rnd_out", {24'b0, gout}, {24'b0, m_out});
                end
                default: begin
                    ra = 5'($urandom_range(0, 31));
                    bus_read(ra, rd);
                    chk($sformatf("rnd_rd_%02h", ra), rd, model_read(ra));
                end
            endcase
            @(negedge clk);
            chk("rnd_irq", {31'b0, irq}, {31'b0, |(m_status & m_mask)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
